// File: rtl/red_pkg.sv
// Shared types and saturation rails for the RED accumulator path.
package red_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/sat_add16.sv
// Combinational 16-bit signed adder that clamps to the 16-bit rails and flags clamping.
module sat_add16
    import red_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o,
    output logic        sat_o
);

    logic signed [16:0] raw;

    always_comb begin
        raw   = $signed({a_i[15], a_i}) + $signed({b_i[15], b_i});
        sum_o = raw[15:0];
        sat_o = 1'b0;
        // Bits 16 and 15 disagree only when the true sum left the 16-bit range.
        if (raw[16] != raw[15]) begin
            sat_o = 1'b1;
            sum_o = raw[16] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/red_accum.sv
// Streaming saturating accumulator over a programmed number of RED results,
// presenting the total and a sticky overflow flag through a valid/ready output.
module red_accum
    import red_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic             out_ovf,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    logic [15:0]      add_sum;
    logic             add_sat;

    sat_add16 u_add (
        .a_i   (acc_q),
        .b_i   (in_data),
        .sum_o (add_sum),
        .sat_o (add_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = len;
                    state_d = (len != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_sat;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decode the registered state only, so no input feeds them combinationally.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_red_accum.sv
// Randomized and directed bench for red_accum against an integer reference model.
module tb_red_accum;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_sum;
    logic             out_ovf;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;
    int data_q[$];

    red_accum #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer sum clamped after each element.
    task automatic model(output int sum, output bit ovf);
        sum = 0;
        ovf = 1'b0;
        foreach (data_q[i]) begin
            sum = sum + data_q[i];
            if (sum > 32767) begin
                sum = 32767;
                ovf = 1'b1;
            end else if (sum < -32768) begin
                sum = -32768;
                ovf = 1'b1;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_sum"},   32'(out_sum),   32'd0);
        check({tag, "_out_ovf"},   32'(out_ovf),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // Runs one accumulation over data_q; gap toggles in_valid, hold stalls out_ready.
    task automatic run_op(input string tag, input bit gap, input int hold);
        int          n;
        int          idx;
        int          cyc;
        int          exp_sum;
        bit          exp_ovf;
        logic [15:0] held;
        n = data_q.size();
        model(exp_sum, exp_ovf);
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        len   = LEN_W'($urandom);
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        if (n == 0) begin
            check({tag, "_len0_out_valid"}, 32'(out_valid), 32'd1);
        end else begin
            check({tag, "_in_ready_accum"}, 32'(in_ready), 32'd1);
        end
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 4 * n + 8) begin
            in_valid = gap ? (cyc % 2 == 0) : 1'b1;
            in_data  = in_valid ? 16'(data_q[idx]) : 16'($urandom);
            start    = ~in_valid;
            tick();
            if (in_valid) idx++;
            cyc++;
            if (idx < n) begin
                check({tag, "_out_valid_low_accum"}, 32'(out_valid), 32'd0);
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check({tag, "_out_valid_latency"}, 32'(out_valid), 32'd1);
        check({tag, "_out_sum"}, 32'(out_sum), 32'(exp_sum) & 32'hFFFF);
        check({tag, "_out_ovf"}, 32'(out_ovf), 32'(exp_ovf));
        held = out_sum;
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 16'($urandom);
            tick();
            check({tag, "_out_valid_held"}, 32'(out_valid), 32'd1);
            check({tag, "_out_sum_stable"}, 32'(out_sum), 32'(held));
            check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd5;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_start_in_handshake_ignored"}, 32'(busy), 32'd0);
    endtask

    task automatic fill_const(input int n, input int v);
        data_q.delete();
        for (int i = 0; i < n; i++) data_q.push_back(v);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        fill_const(3, 16'h01FE);
        run_op("basic", 1'b0, 0);
        fill_const(70, 16'h01FE);
        run_op("pos_sat", 1'b0, 1);
        fill_const(64, -512);
        run_op("neg_rail64", 1'b0, 0);
        fill_const(65, -512);
        run_op("neg_rail65", 1'b0, 0);
        data_q = '{100, -37, 510, -512};
        run_op("handshake", 1'b1, 5);
        data_q.delete();
        run_op("len0", 1'b0, 2);

        // Reset in the middle of an accumulation discards the partial sum.
        start = 1'b1;
        len   = 8'd10;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h01FE;
            tick();
        end
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check_reset_outputs("mid_reset");
        fill_const(1, -1);
        run_op("after_reset", 1'b0, 0);

        for (int t = 0; t < 25; t++) begin
            int n;
            int bias;
            n = $urandom_range(0, 90);
            bias = $urandom_range(0, 2);
            data_q.delete();
            for (int i = 0; i < n; i++) begin
                if (bias == 1)      data_q.push_back($urandom_range(300, 510));
                else if (bias == 2) data_q.push_back(-int'($urandom_range(300, 512)));
                else                data_q.push_back(int'($urandom_range(0, 1022)) - 512);
            end
            run_op($sformatf("rand%0d", t), 1'($urandom), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
